// File: rtl/aes_req_arb.sv
// Round-robin scheduler sharing one AES core among NUM_REQ requesters.
// Ports: clk/reset; req[] in; gnt[]/gnt_id/done[]/err[] out to requesters;
//        core_start out, core_ready/core_ready_1 in from core control; busy out.
// Latency: req to core_start is 1 cycle with an idle core; nominal req to done is 12 cycles.
// Backpressure: grants are withheld while core_ready is low; req is a level held until done/err.
module aes_req_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               core_start,
  input  logic               core_ready,
  input  logic               core_ready_1,
  output logic               busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [WD_W-1:0] wd_cnt;
  logic            seen_last;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] scan_idx;

  // Winner search starts just after the last granted index and wraps,
  // so the previous grantee has the lowest priority in the next round.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      wd_cnt     <= '0;
      seen_last  <= 1'b0;
      gnt        <= '0;
      gnt_id     <= '0;
      done       <= '0;
      err        <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle below.
      core_start <= 1'b0;
      done       <= '0;
      err        <= '0;
      case (state)
        IDLE: begin
          if (core_ready && win_found) begin
            state      <= START;
            gnt        <= NUM_REQ'(1) << win_id;
            gnt_id     <= win_id;
            rr_ptr     <= win_id;
            core_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        START: begin
          state     <= BUSY;
          wd_cnt    <= '0;
          seen_last <= 1'b0;
        end
        BUSY: begin
          if (wd_cnt != WD_W'(TIMEOUT))
            wd_cnt <= wd_cnt + 1'b1;
          if (core_ready_1)
            seen_last <= 1'b1;
          // Completion is checked first so it wins over a coincident timeout.
          if (core_ready) begin
            state <= DONE;
            if (seen_last) done <= gnt;
            else           err  <= gnt;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            state <= DONE;
            err   <= gnt;
          end
        end
        DONE: begin
          state  <= IDLE;
          gnt    <= '0;
          gnt_id <= '0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_start_only_in_start: assert property (@(posedge clk) disable iff (reset)
    core_start |-> (state == START));
  a_done_err_excl: assert property (@(posedge clk) disable iff (reset)
    !((|done) && (|err)));

endmodule
